debug_host_ctrl: RTL

- Initiator end of the MIPS debug-unit UART protocol, used for on-board self-test and host emulation.
- Loads a program into the target: start byte, then 32-bit words sent LSB first, ending with the halt word.
- Issues mode and step commands, then receives the state-dump frame and writes each reassembled 32-bit word to a capture RAM port.
- Sits between a program ROM, a command source and the UART tx/rx pair.

---
 rtl/debug_host_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/debug_host_ctrl.sv
// Debug-unit UART initiator: downloads a program from ROM, issues mode/step commands and captures the state-dump frame.
// Optional rx inter-byte watchdog enabled with `define DEBUG_HOST_RX_TIMEOUT_EN.
module debug_host_ctrl #(
    parameter int len                = 32,
    parameter int cant_instrucciones = 64,
    parameter int cant_regs          = 32,
    parameter int cant_mem_datos     = 16,
    parameter int hdr_words          = 6,
    parameter int LEN_DATA           = 8,
    parameter int TIMEOUT_CYCLES     = 1000000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    output logic [$clog2(cant_instrucciones)-1:0] prog_addr,
    input  logic [len-1:0]                        prog_data,
    input  logic                                  load_req,
    input  logic                                  cmd_valid,
    input  logic [7:0]                            cmd_code,
    output logic                                  cmd_ready,
    output logic                                  tx_start,
    output logic [LEN_DATA-1:0]                   uart_data_out,
    input  logic                                  tx_done,
    input  logic                                  rx_done,
    input  logic [LEN_DATA-1:0]                   uart_data_in,
    output logic                                  dump_we,
    output logic [7:0]                            dump_addr,
    output logic [len-1:0]                        dump_data,
    output logic                                  frame_done,
    output logic                                  busy,
    output logic                                  prog_overflow,
    output logic                                  rx_timeout
);
    localparam int AW          = $clog2(cant_instrucciones);
    localparam int FRAME_WORDS = hdr_words + cant_regs + cant_mem_datos;
    localparam logic [7:0]    LAST_WORD = 8'(FRAME_WORDS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(cant_instrucciones - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_START, FETCH, SEND_WORD, WAIT_CMD, SEND_CMD, RX_DUMP
    } state_t;

    state_t              state_reg;
    logic [1:0]          tx_phase_reg;
    logic [1:0]          byte_cnt_reg;
    logic [7:0]          word_cnt_reg;
    logic [len-1:0]      word_reg;
    logic [len-1:0]      asm_reg;
    logic [7:0]          cmd_reg;
    logic                fetch_wait_reg;
    logic                frame_end_reg;
    logic [LEN_DATA-1:0] tx_byte;
    logic                tx_fin;
    logic                timeout_hit;
    logic                send_state;

`ifdef DEBUG_HOST_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wdog_reg;
    logic          rx_timeout_reg;

    // Counts idle cycles since the last received byte while a frame is being captured.
    assign timeout_hit = (state_reg == RX_DUMP) && !frame_end_reg && !rx_done &&
                         (wdog_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_reg       <= '0;
            rx_timeout_reg <= 1'b0;
        end else begin
            if (state_reg != RX_DUMP || rx_done || timeout_hit)
                wdog_reg <= '0;
            else
                wdog_reg <= wdog_reg + 1'b1;
            if (timeout_hit)
                rx_timeout_reg <= 1'b1;
        end
    end
    assign rx_timeout = rx_timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign rx_timeout  = 1'b0;
`endif

    assign cmd_ready  = (state_reg == WAIT_CMD);
    assign busy       = (state_reg != IDLE) && (state_reg != WAIT_CMD);
    assign send_state = (state_reg == SEND_START) || (state_reg == SEND_WORD) ||
                        (state_reg == SEND_CMD);
    // tx_done only counts while our own request is up.
    assign tx_fin     = send_state && (tx_phase_reg == 2'd2) && tx_start && tx_done;

    always_comb begin
        tx_byte = LEN_DATA'(1);
        case (state_reg)
            SEND_WORD: tx_byte = word_reg[{byte_cnt_reg, 3'b000} +: LEN_DATA];
            SEND_CMD:  tx_byte = LEN_DATA'(cmd_reg);
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            tx_phase_reg   <= 2'd0;
            byte_cnt_reg   <= 2'd0;
            word_cnt_reg   <= 8'd0;
            word_reg       <= '0;
            asm_reg        <= '0;
            cmd_reg        <= 8'd0;
            fetch_wait_reg <= 1'b0;
            frame_end_reg  <= 1'b0;
            prog_addr      <= '0;
            tx_start       <= 1'b0;
            uart_data_out  <= '0;
            dump_we        <= 1'b0;
            dump_addr      <= 8'd0;
            dump_data      <= '0;
            frame_done     <= 1'b0;
            prog_overflow  <= 1'b0;
        end else begin
            dump_we    <= 1'b0;
            frame_done <= 1'b0;

            // Byte handshake: present data, raise tx_start a cycle later, drop it on tx_done.
            if (send_state) begin
                case (tx_phase_reg)
                    2'd0: begin
                        uart_data_out <= tx_byte;
                        tx_phase_reg  <= 2'd1;
                    end
                    2'd1: begin
                        tx_start     <= 1'b1;
                        tx_phase_reg <= 2'd2;
                    end
                    default: begin
                        if (tx_fin) begin
                            tx_start     <= 1'b0;
                            tx_phase_reg <= 2'd0;
                        end
                    end
                endcase
            end

            case (state_reg)
                IDLE: begin
                    if (load_req) begin
                        prog_addr    <= '0;
                        tx_phase_reg <= 2'd0;
                        state_reg    <= SEND_START;
                    end
                end
                SEND_START: begin
                    if (tx_fin) begin
                        fetch_wait_reg <= 1'b0;
                        state_reg      <= FETCH;
                    end
                end
                FETCH: begin
                    // ROM output is registered: give it one full cycle on the new address.
                    if (!fetch_wait_reg) begin
                        fetch_wait_reg <= 1'b1;
                    end else begin
                        word_reg     <= prog_data;
                        byte_cnt_reg <= 2'd0;
                        state_reg    <= SEND_WORD;
                    end
                end
                SEND_WORD: begin
                    if (tx_fin) begin
                        if (byte_cnt_reg == 2'd3) begin
                            byte_cnt_reg <= 2'd0;
                            if (word_reg[len-1 -: 6] == 6'b111111) begin
                                state_reg <= WAIT_CMD;
                            end else if (prog_addr == LAST_ADDR) begin
                                prog_overflow <= 1'b1;
                                state_reg     <= WAIT_CMD;
                            end else begin
                                prog_addr      <= prog_addr + 1'b1;
                                fetch_wait_reg <= 1'b0;
                                state_reg      <= FETCH;
                            end
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                    end
                end
                WAIT_CMD: begin
                    if (cmd_valid && (cmd_code inside {8'h02, 8'h03, 8'h05, 8'h06})) begin
                        cmd_reg      <= cmd_code;
                        tx_phase_reg <= 2'd0;
                        state_reg    <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (tx_fin) begin
                        case (cmd_reg)
                            8'h02, 8'h06: begin
                                byte_cnt_reg  <= 2'd0;
                                word_cnt_reg  <= 8'd0;
                                asm_reg       <= '0;
                                frame_end_reg <= 1'b0;
                                state_reg     <= RX_DUMP;
                            end
                            8'h03:   state_reg <= WAIT_CMD;
                            default: state_reg <= IDLE;
                        endcase
                    end
                end
                RX_DUMP: begin
                    if (frame_end_reg || timeout_hit) begin
                        frame_done    <= frame_end_reg;
                        frame_end_reg <= 1'b0;
                        word_cnt_reg  <= 8'd0;
                        byte_cnt_reg  <= 2'd0;
                        asm_reg       <= '0;
                        state_reg     <= WAIT_CMD;
                    end else if (rx_done) begin
                        if (byte_cnt_reg == 2'd3) begin
                            dump_we      <= 1'b1;
                            dump_addr    <= word_cnt_reg;
                            dump_data    <= {uart_data_in, asm_reg[len-LEN_DATA-1:0]};
                            word_cnt_reg <= word_cnt_reg + 8'd1;
                            byte_cnt_reg <= 2'd0;
                            asm_reg      <= '0;
                            if (word_cnt_reg == LAST_WORD)
                                frame_end_reg <= 1'b1;
                        end else begin
                            asm_reg[{byte_cnt_reg, 3'b000} +: LEN_DATA] <= uart_data_in;
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
